i2s_dac_tx: RTL

- Downstream consumer of the synthesizer's stereo sample outputs (lsound_out/rsound_out).
- Buffers one stereo sample per audio frame and serializes it to the codec DAC in I2S format: BCLK, LRCK, DACDAT.
- Emits a frame_start pulse once per frame; the synth engine uses it as its trig to compute the next sample.
- Runs entirely in the AUDIO_CLK domain.

---
 rtl/i2s_dac_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the codec DAC: one-deep stereo sample buffer, BCLK/LRCK
// generation and MSB-first serialisation with the standard one-BCLK data delay.
module i2s_dac_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  AUDIO_CLK,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] lsound_in,
    input  logic [DATA_WIDTH-1:0] rsound_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  frame_start,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(DATA_WIDTH);
    localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_WIDTH + 1);
    localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_WIDTH + DATA_WIDTH);

    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic                  div_wrap, frame_wrap, accept;
    logic                  left_slot, right_slot;
    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_l, buf_r;
    logic [DATA_WIDTH-1:0] last_l, last_r;
    logic [DATA_WIDTH-1:0] sh_l, sh_r;

    // Outputs are registered from the next counter values so they line up
    // with the counters cycle for cycle.
    always_comb begin
        div_wrap   = (div_cnt == DIV_LAST);
        frame_wrap = div_wrap && (bit_cnt == BIT_LAST);
        div_nxt    = div_wrap ? '0 : div_cnt + 1'b1;
        bit_nxt    = bit_cnt;
        if (div_wrap) begin
            bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        left_slot  = (bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST);
        right_slot = (bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST);
        accept     = sample_valid & sample_ready;
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            buf_full     <= 1'b0;
            buf_l        <= '0;
            buf_r        <= '0;
            last_l       <= '0;
            last_r       <= '0;
            sh_l         <= '0;
            sh_r         <= '0;
            sample_ready <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            AUD_BCLK     <= 1'b0;
            AUD_DACLRCK  <= 1'b0;
            AUD_DACDAT   <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            bit_cnt     <= bit_nxt;
            AUD_BCLK    <= (div_nxt >= DIV_HALF);
            AUD_DACLRCK <= (bit_nxt >= SLOT);
            frame_start <= frame_wrap;
            // Stays low for one cycle after the buffer drains at a boundary.
            sample_ready <= ~buf_full & ~accept;
            buf_full     <= accept | (buf_full & ~frame_wrap);

            if (accept) begin
                buf_l <= lsound_in;
                buf_r <= rsound_in;
            end

            if (frame_wrap) begin
                if (buf_full) begin
                    sh_l   <= buf_l;
                    sh_r   <= buf_r;
                    last_l <= buf_l;
                    last_r <= buf_r;
                end else begin
                    sh_l <= last_l;
                    sh_r <= last_r;
                end
            end else if (div_wrap) begin
                if (left_slot)  sh_l <= sh_l << 1;
                if (right_slot) sh_r <= sh_r << 1;
            end

            if (frame_wrap && !buf_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            // Data only moves on the BCLK falling edge (divider wrap).
            if (div_wrap) begin
                if (left_slot) begin
                    AUD_DACDAT <= sh_l[DATA_WIDTH-1];
                end else if (right_slot) begin
                    AUD_DACDAT <= sh_r[DATA_WIDTH-1];
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule
